// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// The state encoding for the serial subtractor's controller is defined here.
// The default operand width is also defined here and is shared with the ripple-carry adder.
// This package has no ports.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle between the ALU control and the serial subtractor.
//   start     : request, only honoured while busy is low
//   A, B, B0  : minuend, subtrahend and borrow-in, captured with start
//   busy      : a subtraction is in progress
//   done      : one-cycle pulse, results valid from this cycle on
//   Diff      : A - B - B0 mod 2^WIDTH
//   Bout      : borrow out of the MSB
//   Zero      : Diff == 0
//   Overflow  : signed overflow of the subtraction
// master = ALU control side, slave = subtractor side.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Zero;
  logic             Overflow;

  modport master (
    output start, A, B, B0,
    input  busy, done, Diff, Bout, Zero, Overflow
  );

  modport slave (
    input  start, A, B, B0,
    output busy, done, Diff, Bout, Zero, Overflow
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell.
// It computes d = a - b - bin together with the borrow out.
//   a_i, b_i, bin_i : operand bits and borrow in
//   d_o             : difference bit
//   bout_o          : borrow out
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  // A borrow is needed when b exceeds a, or when the bits are equal and a borrow arrives.
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor.
// It computes Diff = A - B - B0 one bit per clock, LSB first, through a single full_subtractor cell.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of serial_subtractor_if (start/operands in, busy/done/results out)
// A result takes WIDTH SHIFT cycles.
// done pulses on the edge that completes the MSB.
// The result registers hold until the next result completes.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             bitDiff;
  logic             bitBorrow;
  logic [WIDTH-1:0] resShifted;

  full_subtractor u_cell (
    .a_i    (aSh_q[0]),
    .b_i    (bSh_q[0]),
    .bin_i  (borrow_q),
    .d_o    (bitDiff),
    .bout_o (bitBorrow)
  );

  // New bits enter at the MSB, so after WIDTH shifts the first (LSB) bit reaches position 0.
  assign resShifted = {bitDiff, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      aSh_q    <= '0;
      bSh_q    <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A request made in the DONE cycle is accepted so that operations can run back to back.
        if (bus.start) begin
          aSh_d    = bus.A;
          bSh_d    = bus.B;
          borrow_d = bus.B0;
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        aSh_d    = aSh_q >> 1;
        bSh_d    = bSh_q >> 1;
        res_d    = resShifted;
        borrow_d = bitBorrow;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // borrow_q is the borrow into the MSB here.
          // Signed overflow is that borrow XOR the borrow out of the MSB.
          diff_d  = resShifted;
          bout_d  = bitBorrow;
          zero_d  = (resShifted == '0);
          ovf_d   = borrow_q ^ bitBorrow;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q == S_SHIFT);
  assign bus.done     = (state_q == S_DONE);
  assign bus.Diff     = diff_q;
  assign bus.Bout     = bout_q;
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle, bit-serial two's-complement subtractor for the ALU: computes Diff = A − B − B0 one bit per clock, LSB first, through a single 1-bit full-subtractor cell. It mirrors the combinational ripple-carry adder by performing the inverse operation as a handshaked sequential unit. The ALU control issues a `start` and waits for `done`. Outputs are registered and hold until the next result.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy = 0
- A  input  WIDTH  minuend; sampled with start
- B  input  WIDTH  subtrahend; sampled with start
- B0  input  1  borrow-in; sampled with start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; the result outputs are valid from this cycle on
- Diff  output  WIDTH  A − B − B0, mod 2^WIDTH
- Bout  output  1  borrow out of the MSB (unsigned A < B + B0)
- Zero  output  1  Diff == 0
- Overflow  output  1  signed overflow = (borrow into MSB) XOR Bout

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: busy = 0, done = 0, Diff = 0, Bout = 0, Zero = 0, Overflow = 0. The internal shift registers, borrow flop and bit counter are also cleared.
- **IDLE or DONE, start = 1:**
  - Latch A, B and B0 (B0 loads the borrow flop).
  - Clear the bit counter.
  - Go to SHIFT.
- **IDLE, start = 0:** stay in IDLE.
- **DONE, start = 0:** go to IDLE.
- **SHIFT, each cycle:**
  - Take bit a = A_sh[0], b = B_sh[0] and br = borrow flop.
  - Compute d = a ^ b ^ br and br' = (~a & b) | (~(a ^ b) & br).
  - Shift d into the MSB of the result register; shift A_sh and B_sh right by one.
  - Load br' into the borrow flop and increment the counter.
- **Last SHIFT cycle** (counter == WIDTH−1):
  - Keep the br value entering this bit as borrow-into-MSB.
  - Load the Diff, Bout (= br'), Zero and Overflow registers.
  - Go to DONE.
- start while in SHIFT is ignored; it is neither queued nor does it corrupt the operation.
- Result registers change only on the last SHIFT cycle or on reset.
- Reset asserted mid-operation: the block aborts at once and all outputs return to their reset values. No done is produced for the aborted operation.

## Timing
- Let E0 be the edge that samples start. SHIFT then occupies edges E1..E_WIDTH; on edge E_WIDTH the state moves to DONE.
- busy is high from after E0 until after E_WIDTH, i.e. exactly WIDTH cycles.
- done is high for one cycle, between E_WIDTH and E_WIDTH+1. Diff, Bout, Zero and Overflow are valid in the same cycle and stay stable afterwards.
- Latency from start to done is WIDTH+1 edges (9 at the default width).
- Throughput: start asserted during the done cycle is accepted. Back-to-back operations therefore issue every WIDTH+1 cycles.
- busy and done are never high together.

## Structure
- Package `alu_pkg`:
  - state-encoding localparams S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
  - the default operand width, ALU_WIDTH = 8, shared with the ripple-carry adder.
- Sub-module `full_subtractor` (a, b, bin → d, bout), purely combinational. It is instantiated once in the serial path.
- The counter width is $clog2(WIDTH). No other logic.

## Test plan
- **Basic, no borrow-in:** A = 8'b10010110, B = 8'b01110001, B0 = 0, start.
  - done on the 9th edge after start.
  - Diff = 8'h25, Bout = 0, Zero = 0, Overflow = 1.
- **With borrow-in:** A = 8'b01010100, B = 8'b00110101, B0 = 1.
  - Diff = 8'h1E, Bout = 0, Overflow = 0.
- **Underflow and zero:**
  - A = 8'h00, B = 8'b00100100, B0 = 0 → Diff = 8'hDC, Bout = 1, Overflow = 0.
  - Then A = B = 8'h24 → Diff = 8'h00, Zero = 1, Bout = 0.
- **Signed overflow and busy/done timing:** A = 8'h80, B = 8'h01, B0 = 0.
  - Diff = 8'h7F, Overflow = 1, Bout = 0.
  - busy high for exactly 8 cycles; done is a single-cycle pulse.
- **Handshake boundaries:**
  - start re-asserted during SHIFT with new operands → ignored, result unchanged.
  - start asserted during the done cycle → accepted; the second done follows 9 edges later.
- **Reset mid-operation:** drop rst_n at SHIFT cycle 4, asynchronously between edges.
  - All outputs are 0 immediately; no done pulse appears.
  - After release, a fresh start produces a correct result.
